ram_dump_module: RTL and testbench

Downstream consumer of the ROM-to-RAM copy stage. After the copy controller has filled the 16-word buffer RAM, the top-level sequencer asserts this block's start_sig. The block reads RAM addresses 0..15 through the RAM's registered read port and streams the words out on a valid/ready interface. It accumulates an 8-bit checksum and reports completion with the same start/done pulse protocol the copy stage uses.

---
 rtl/ram_dump_module.sv | 226 ++++++++++++++++++++++
 tb/tb_ram_dump_module.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_module.sv
// ram_dump_module
// Reads the 16-word buffer RAM (addresses 0..DEPTH-1) through its registered
// read port once the sequencer raises start_sig. It streams the words out on a
// valid/ready interface, accumulates a wrapping checksum, and pulses done_sig
// when the pass is complete.
//
// Ports
//   clk, rst_n        system clock (rising edge), asynchronous active-low reset
//   start_sig         level, held high by the sequencer for the whole pass
//   done_sig          one-cycle completion pulse
//   ram_rd_en         RAM read strobe; ram_addr is valid with it
//   ram_rd_data       RAM data, valid exactly one cycle after ram_rd_en
//   out_data/out_valid/out_ready/out_last   output stream
//   checksum          sum of all words of the last completed pass, mod 2^DATA_W
//
// Buffering: the stream head lives in the registered output stage
// (out_valid/out_data). A 2-entry skid FIFO sits behind it and absorbs the
// words still in flight from the RAM when the consumer stalls. Between the
// head stage, the skid FIFO and the two-cycle issue-to-head latency, one word
// per cycle is sustained with out_ready high, and nothing overflows under a
// stall.
module ram_dump_module #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_sig,
  output logic              done_sig,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [DATA_W-1:0] checksum
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, DONE, RECOVER} state_t;

  // Checksum addition wraps modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] add_wrap(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic [DATA_W-1:0]   checksum_q, checksum_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic                rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   skid0_q, skid0_d;
  logic [DATA_W-1:0]   skid1_q, skid1_d;
  logic [1:0]          skid_cnt_q, skid_cnt_d;

  logic                pop;
  logic                land_v;
  logic [1:0]          cnt_v;

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    beat_cnt_d  = beat_cnt_q;
    sum_d       = sum_q;
    checksum_d  = checksum_q;
    done_d      = 1'b0;
    rd_en_d     = 1'b0;
    rd_vld_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    skid0_d     = skid0_q;
    skid1_d     = skid1_q;
    skid_cnt_d  = skid_cnt_q;
    pop         = out_valid_q & out_ready;
    land_v      = rd_vld_q;
    cnt_v       = skid_cnt_q;

    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        skid_cnt_d  = 2'd0;
        if (start_sig) begin
          // The first read is issued in the very next cycle.
          state_d    = READ;
          rd_en_d    = 1'b1;
          ram_addr_d = '0;
          rd_cnt_d   = CNT_W'(1);
          beat_cnt_d = '0;
          sum_d      = '0;
        end
      end

      READ: begin
        if (!start_sig) begin
          // Abort: drop buffered words and ignore the read still in flight.
          state_d     = IDLE;
          out_valid_d = 1'b0;
          skid_cnt_d  = 2'd0;
        end else if (pop && (beat_cnt_q == LAST_C)) begin
          state_d     = DONE;
          done_d      = 1'b1;
          sum_d       = add_wrap(sum_q, out_data_q);
          checksum_d  = add_wrap(sum_q, out_data_q);
          beat_cnt_d  = beat_cnt_q + CNT_W'(1);
          out_valid_d = 1'b0;
          skid_cnt_d  = 2'd0;
        end else begin
          if (pop) begin
            sum_d      = add_wrap(sum_q, out_data_q);
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end

          // Refill the head stage: oldest skid entry first, else the word
          // arriving from the RAM this cycle.
          if (!out_valid_q || pop) begin
            if (skid_cnt_q != 2'd0) begin
              out_valid_d = 1'b1;
              out_data_d  = skid0_q;
              skid0_d     = skid1_q;
              cnt_v       = skid_cnt_q - 2'd1;
            end else if (rd_vld_q) begin
              out_valid_d = 1'b1;
              out_data_d  = ram_rd_data;
              land_v      = 1'b0;
            end else begin
              out_valid_d = 1'b0;
            end
          end

          // A RAM word not taken by the head stage goes to the skid FIFO tail.
          if (land_v) begin
            if (cnt_v == 2'd0) begin
              skid0_d = ram_rd_data;
            end else begin
              skid1_d = ram_rd_data;
            end
            cnt_v = cnt_v + 2'd1;
          end
          skid_cnt_d = cnt_v;
          out_last_d = out_valid_d && (beat_cnt_d == LAST_C);

          // Issue only while the skid FIFO plus the read already on the RAM
          // port leaves room, so stalled data always has a slot.
          rd_vld_d = rd_en_q;
          if ((rd_cnt_q < DEPTH_C) && (({1'b0, cnt_v} + {2'b00, rd_en_q}) < 3'd2)) begin
            rd_en_d    = 1'b1;
            ram_addr_d = rd_cnt_q[ADDR_W-1:0];
            rd_cnt_d   = rd_cnt_q + CNT_W'(1);
          end
        end
      end

      DONE: begin
        state_d = RECOVER;
      end

      RECOVER: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_cnt_q    <= '0;
      beat_cnt_q  <= '0;
      sum_q       <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_vld_q    <= 1'b0;
      ram_addr_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid0_q     <= '0;
      skid1_q     <= '0;
      skid_cnt_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      rd_cnt_q    <= rd_cnt_d;
      beat_cnt_q  <= beat_cnt_d;
      sum_q       <= sum_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
      rd_en_q     <= rd_en_d;
      rd_vld_q    <= rd_vld_d;
      ram_addr_q  <= ram_addr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid0_q     <= skid0_d;
      skid1_q     <= skid1_d;
      skid_cnt_q  <= skid_cnt_d;
    end
  end

  assign done_sig  = done_q;
  assign ram_rd_en = rd_en_q;
  assign ram_addr  = ram_addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_ram_dump_module.sv
// Bench for ram_dump_module: a RAM with a registered read port, directed
// passes (free-flowing, stalled, toggling ready, abort, mid-pass reset,
// back-to-back passes) and a stream model that expects each pass to deliver
// RAM[0..15] in order with a wrapping checksum.
module tb_ram_dump_module;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_sig;
  logic       done_sig;
  logic       ram_rd_en;
  logic [3:0] ram_addr;
  logic [7:0] ram_rd_data = 8'h00;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [7:0] checksum;

  logic [7:0] mem [16];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         done_seen = 0;

  // Stream model state
  int         exp_idx = 0;
  logic [7:0] run_sum = 8'h00;
  logic [7:0] model_ck = 8'h00;
  logic       prev_start_low = 1'b0;
  logic       prev_stall = 1'b0;
  logic       prev_done = 1'b0;
  logic [7:0] held = 8'h00;

  ram_dump_module dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_sig  (start_sig),
    .done_sig   (done_sig),
    .ram_rd_en  (ram_rd_en),
    .ram_addr   (ram_addr),
    .ram_rd_data(ram_rd_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Buffer RAM with a registered read port.
  always @(posedge clk) if (ram_rd_en) ram_rd_data <= mem[ram_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the stream model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0;
      run_sum = 8'h00;
      model_ck = 8'h00;
      prev_start_low = 1'b0;
      prev_stall = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (prev_start_low) chk("valid_after_start_low", 32'(out_valid), 32'd0);
      if (prev_stall) begin
        chk("stall_valid_held", 32'(out_valid), 32'd1);
        chk("stall_data_held", 32'(out_data), 32'(held));
      end
      chk("last_flag", 32'(out_last), 32'(out_valid && (exp_idx == 15)));
      if (done_sig) begin
        done_seen++;
        chk("done_beats", 32'(exp_idx), 32'd16);
        chk("done_checksum", 32'(checksum), 32'(run_sum));
        chk("done_single_cycle", 32'(prev_done), 32'd0);
        model_ck = run_sum;
      end else begin
        chk("checksum_stable", 32'(checksum), 32'(model_ck));
      end
      if (out_valid && out_ready && start_sig) begin
        if (exp_idx < 16) begin
          chk("beat_data", 32'(out_data), 32'(mem[exp_idx]));
        end else begin
          chk("beat_extra", 32'(exp_idx), 32'd15);
        end
        run_sum = run_sum + out_data;
        exp_idx++;
      end
      prev_start_low = !start_sig;
      prev_stall = out_valid && !out_ready && start_sig;
      held = out_data;
      prev_done = done_sig;
      if (done_sig || !start_sig) begin
        exp_idx = 0;
        run_sum = 8'h00;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done_sig && n < limit) begin
      step();
      n++;
    end
    if (!done_sig) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_values();
    chk("rst_done", 32'(done_sig), 32'd0);
    chk("rst_rd_en", 32'(ram_rd_en), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

  initial begin
    int c0;
    int d1;
    int ds;
    for (int i = 0; i < 16; i++) mem[i] = 8'h10 + 8'(i);
    rst_n = 1'b0;
    start_sig = 1'b0;
    out_ready = 1'b1;
    #23;
    check_reset_values();
    step();
    rst_n = 1'b1;
    step();
    step();

    // Pass 1: free-flowing stream, timing pinned to literal cycles.
    ds = done_seen;
    c0 = cyc;
    start_sig = 1'b1;
    step();
    chk("p1_first_rd_en", 32'(ram_rd_en), 32'd1);
    chk("p1_first_addr", 32'(ram_addr), 32'd0);
    step();
    step();
    chk("p1_first_valid", 32'(out_valid), 32'd1);
    chk("p1_first_word", 32'(out_data), 32'h10);
    wait_done(60);
    chk("p1_done_cycle", 32'(cyc - c0), 32'd19);
    chk("p1_checksum", 32'(checksum), 32'h78);
    start_sig = 1'b0;
    repeat (4) step();
    chk("p1_done_count", 32'(done_seen - ds), 32'd1);

    // Pass 2: stall 5 cycles with word 3 at the head.
    ds = done_seen;
    c0 = cyc;
    start_sig = 1'b1;
    repeat (6) step();
    chk("p2_head_before_stall", 32'(out_data), 32'h13);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("p2_stall_word", 32'(out_data), 32'h13);
      chk("p2_stall_valid", 32'(out_valid), 32'd1);
      if (k > 0) chk("p2_stall_rd_en", 32'(ram_rd_en), 32'd0);
      step();
    end
    out_ready = 1'b1;
    wait_done(60);
    chk("p2_done_cycle", 32'(cyc - c0), 32'd24);
    chk("p2_checksum", 32'(checksum), 32'h78);
    start_sig = 1'b0;
    repeat (4) step();
    chk("p2_done_count", 32'(done_seen - ds), 32'd1);

    // Pass 3: out_ready toggling every cycle.
    ds = done_seen;
    start_sig = 1'b1;
    for (int n = 0; n < 200; n++) begin
      step();
      if (done_sig) break;
      out_ready = !out_ready;
    end
    if (!done_sig) chk("p3_done_timeout", 32'd0, 32'd1);
    chk("p3_checksum", 32'(checksum), 32'h78);
    start_sig = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("p3_done_count", 32'(done_seen - ds), 32'd1);

    // Pass 4: abort after 7 accepted beats, then restart with new data.
    ds = done_seen;
    start_sig = 1'b1;
    repeat (10) step();
    start_sig = 1'b0;
    out_ready = 1'b0;
    step();
    chk("p4_abort_valid", 32'(out_valid), 32'd0);
    chk("p4_abort_checksum", 32'(checksum), 32'h78);
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(3 * i);
    repeat (3) step();
    chk("p4_abort_no_done", 32'(done_seen - ds), 32'd0);
    out_ready = 1'b1;
    start_sig = 1'b1;
    step();
    chk("p4_restart_rd_en", 32'(ram_rd_en), 32'd1);
    chk("p4_restart_addr", 32'(ram_addr), 32'd0);
    step();
    step();
    chk("p4_restart_word", 32'(out_data), 32'hA0);
    wait_done(60);
    chk("p4_checksum", 32'(checksum), 32'h68);
    start_sig = 1'b0;
    repeat (4) step();

    // Pass 5: asynchronous reset in the middle of a pass.
    start_sig = 1'b1;
    repeat (5) step();
    rst_n = 1'b0;
    start_sig = 1'b0;
    #1;
    check_reset_values();
    step();
    step();
    rst_n = 1'b1;
    step();
    start_sig = 1'b1;
    step();
    chk("p5_restart_addr", 32'(ram_addr), 32'd0);
    chk("p5_restart_rd_en", 32'(ram_rd_en), 32'd1);
    wait_done(60);
    chk("p5_checksum", 32'(checksum), 32'h68);
    start_sig = 1'b0;
    repeat (4) step();

    // Pass 6: start held through done -> back-to-back passes.
    ds = done_seen;
    c0 = cyc;
    start_sig = 1'b1;
    wait_done(60);
    chk("p6_first_done_cycle", 32'(cyc - c0), 32'd19);
    d1 = cyc;
    repeat (3) step();
    chk("p6_second_rd_en", 32'(ram_rd_en), 32'd1);
    chk("p6_second_addr", 32'(ram_addr), 32'd0);
    wait_done(60);
    chk("p6_second_done_gap", 32'(cyc - d1), 32'd21);
    chk("p6_checksum", 32'(checksum), 32'h68);
    start_sig = 1'b0;
    repeat (4) step();
    chk("p6_done_count", 32'(done_seen - ds), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
